// File: rtl/l2_port_txn_guard_if.sv
// -----------------------------------------------------------------------------
// l2_port_txn_guard_if
// AR/AW request handshakes and R/B response observation for one L2 slave port.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

interface l2_port_txn_guard_if;
    // Suffixes are from the guard's point of view
    logic ar_valid_i;
    logic ar_ready_o;
    logic ar_valid_o;
    logic ar_ready_i;
    logic aw_valid_i;
    logic aw_ready_o;
    logic aw_valid_o;
    logic aw_ready_i;
    logic r_valid_i;
    logic r_ready_i;
    logic r_last_i;
    logic b_valid_i;
    logic b_ready_i;

    modport slave (
        input  ar_valid_i, ar_ready_i, aw_valid_i, aw_ready_i,
        input  r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i,
        output ar_ready_o, ar_valid_o, aw_ready_o, aw_valid_o
    );

    modport master (
        output ar_valid_i, ar_ready_i, aw_valid_i, aw_ready_i,
        output r_valid_i, r_ready_i, r_last_i, b_valid_i, b_ready_i,
        input  ar_ready_o, ar_valid_o, aw_ready_o, aw_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/l2_port_txn_guard.sv
// -----------------------------------------------------------------------------
// l2_port_txn_guard
// Outstanding-transaction cap, response watchdog and drain/isolate FSM.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module l2_port_txn_guard #(
    parameter int  MAX_READ_TXNS  = 8,
    parameter int  MAX_WRITE_TXNS = 8,
    parameter int  TIMEOUT_CYCLES = 1024,
    localparam int CNT_WIDTH      = $clog2(((MAX_READ_TXNS > MAX_WRITE_TXNS) ?
                                            MAX_READ_TXNS : MAX_WRITE_TXNS) + 1)
) (
    input  wire logic                 clk_i,
    input  wire logic                 rst_i,
    l2_port_txn_guard_if.slave        bus,
    input  wire logic                 drain_req_i,
    input  wire logic                 clr_i,
    output logic                      drained_o,
    output logic [CNT_WIDTH-1:0]      rd_cnt_o,
    output logic [CNT_WIDTH-1:0]      wr_cnt_o,
    output logic                      timeout_o,
    output logic                      underflow_o
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DRAINED = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] c_rd_max  = CNT_WIDTH'(MAX_READ_TXNS);
    localparam logic [CNT_WIDTH-1:0] c_wr_max  = CNT_WIDTH'(MAX_WRITE_TXNS);
    localparam logic [CNT_WIDTH-1:0] c_one     = CNT_WIDTH'(1);
    localparam logic [15:0]          c_timeout = 16'(TIMEOUT_CYCLES);

    state_t               r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0] r_rd_cnt, r_wr_cnt, w_rd_cnt_nxt, w_wr_cnt_nxt;
    logic [15:0]          r_rd_wd, r_wr_wd, w_rd_wd_nxt, w_wr_wd_nxt;
    logic [15:0]          w_rd_wd_inc, w_wr_wd_inc;
    logic                 r_timeout, r_underflow;
    logic                 w_rd_ok, w_wr_ok, w_ar_hs, w_aw_hs;
    logic                 w_r_beat, w_r_last, w_b_hs;
    logic                 w_rd_unf, w_wr_unf, w_rd_tmo, w_wr_tmo;

    // A drain request closes the gate in the same cycle it is raised
    assign w_rd_ok = (r_state == ST_RUN) && !drain_req_i && (r_rd_cnt < c_rd_max);
    assign w_wr_ok = (r_state == ST_RUN) && !drain_req_i && (r_wr_cnt < c_wr_max);

    assign bus.ar_valid_o = bus.ar_valid_i & w_rd_ok;
    assign bus.ar_ready_o = bus.ar_ready_i & w_rd_ok;
    assign bus.aw_valid_o = bus.aw_valid_i & w_wr_ok;
    assign bus.aw_ready_o = bus.aw_ready_i & w_wr_ok;

    assign w_ar_hs  = bus.ar_valid_o & bus.ar_ready_i;
    assign w_aw_hs  = bus.aw_valid_o & bus.aw_ready_i;
    assign w_r_beat = bus.r_valid_i & bus.r_ready_i;
    assign w_r_last = w_r_beat & bus.r_last_i;
    assign w_b_hs   = bus.b_valid_i & bus.b_ready_i;

    assign w_rd_wd_inc = (r_rd_wd == 16'hFFFF) ? r_rd_wd : r_rd_wd + 16'd1;
    assign w_wr_wd_inc = (r_wr_wd == 16'hFFFF) ? r_wr_wd : r_wr_wd + 16'd1;

    always_comb begin
        w_rd_cnt_nxt = r_rd_cnt;
        w_wr_cnt_nxt = r_wr_cnt;
        w_rd_unf     = 1'b0;
        w_wr_unf     = 1'b0;
        if (w_ar_hs && !w_r_last) begin
            w_rd_cnt_nxt = r_rd_cnt + c_one;
        end else if (w_r_last && !w_ar_hs) begin
            if (r_rd_cnt == '0) w_rd_unf = 1'b1;
            else                w_rd_cnt_nxt = r_rd_cnt - c_one;
        end
        if (w_aw_hs && !w_b_hs) begin
            w_wr_cnt_nxt = r_wr_cnt + c_one;
        end else if (w_b_hs && !w_aw_hs) begin
            if (r_wr_cnt == '0) w_wr_unf = 1'b1;
            else                w_wr_cnt_nxt = r_wr_cnt - c_one;
        end
    end

    // Watchdog restarts after firing so a persisting stall re-flags every period
    always_comb begin
        w_rd_wd_nxt = w_rd_wd_inc;
        w_wr_wd_nxt = w_wr_wd_inc;
        w_rd_tmo    = 1'b0;
        w_wr_tmo    = 1'b0;
        if (r_rd_cnt == '0 || w_r_beat) begin
            w_rd_wd_nxt = '0;
        end else if (TIMEOUT_CYCLES != 0 && w_rd_wd_inc == c_timeout) begin
            w_rd_wd_nxt = '0;
            w_rd_tmo    = 1'b1;
        end
        if (r_wr_cnt == '0 || w_b_hs) begin
            w_wr_wd_nxt = '0;
        end else if (TIMEOUT_CYCLES != 0 && w_wr_wd_inc == c_timeout) begin
            w_wr_wd_nxt = '0;
            w_wr_tmo    = 1'b1;
        end
    end

    // Completion uses next-cycle counts so isolation follows the last response directly
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_RUN: begin
                if (drain_req_i) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (!drain_req_i)
                    w_state_nxt = ST_RUN;
                else if (w_rd_cnt_nxt == '0 && w_wr_cnt_nxt == '0)
                    w_state_nxt = ST_DRAINED;
            end
            ST_DRAINED: begin
                if (!drain_req_i) w_state_nxt = ST_RUN;
            end
            default: w_state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= ST_RUN;
            r_rd_cnt    <= '0;
            r_wr_cnt    <= '0;
            r_rd_wd     <= '0;
            r_wr_wd     <= '0;
            r_timeout   <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_rd_cnt    <= w_rd_cnt_nxt;
            r_wr_cnt    <= w_wr_cnt_nxt;
            r_rd_wd     <= w_rd_wd_nxt;
            r_wr_wd     <= w_wr_wd_nxt;
            r_timeout   <= w_rd_tmo | w_wr_tmo | (r_timeout & ~clr_i);
            r_underflow <= w_rd_unf | w_wr_unf | (r_underflow & ~clr_i);
        end
    end

    assign drained_o   = (r_state == ST_DRAINED);
    assign rd_cnt_o    = r_rd_cnt;
    assign wr_cnt_o    = r_wr_cnt;
    assign timeout_o   = r_timeout;
    assign underflow_o = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_l2_port_txn_guard.sv
// -----------------------------------------------------------------------------
// tb_l2_port_txn_guard
// Directed and random stimulus scored against a count-based reference model.
// Rev 1.0
// -----------------------------------------------------------------------------
`default_nettype none

module tb_l2_port_txn_guard;

    localparam int MAX_RD = 8;
    localparam int MAX_WR = 8;
    localparam int TMO    = 1024;

    typedef struct packed {
        bit rst, arv, arr, awv, awr, rv, rr, rl, bv, br, drn, clr;
    } stim_t;

    typedef struct packed {
        bit       arv, arr, awv, awr;
        bit [3:0] rd, wr;
        bit       tmo, unf, drained;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       drain_req, clr;
    logic       drained;
    logic [3:0] rd_cnt, wr_cnt;
    logic       timeout, underflow;

    l2_port_txn_guard_if bus();

    l2_port_txn_guard #(
        .MAX_READ_TXNS  (MAX_RD),
        .MAX_WRITE_TXNS (MAX_WR),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .drain_req_i (drain_req),
        .clr_i       (clr),
        .drained_o   (drained),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt),
        .timeout_o   (timeout),
        .underflow_o (underflow)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_pass = 0;
    exp_t sb_q[$];

    // Reference model: outstanding counts, mode 0=run 1=drain 2=drained,
    // watchdogs as the edge index of the last progress
    int     m_rd, m_wr, m_mode;
    bit     m_tmo, m_unf;
    longint m_edge, m_rd_mark, m_wr_mark;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic bit rd_open(input bit drn);
        return (m_mode == 0) && !drn && (m_rd < MAX_RD);
    endfunction

    function automatic bit wr_open(input bit drn);
        return (m_mode == 0) && !drn && (m_wr < MAX_WR);
    endfunction

    task automatic model_reset();
        m_rd = 0; m_wr = 0; m_mode = 0; m_tmo = 0; m_unf = 0;
        m_rd_mark = m_edge; m_wr_mark = m_edge;
    endtask

    task automatic model_step(input stim_t s);
        int nrd, nwr;
        bit tset, uset;
        m_edge++;
        if (s.rst) begin
            model_reset();
            return;
        end
        nrd  = m_rd + int'(s.arv && s.arr && rd_open(s.drn)) - int'(s.rv && s.rr && s.rl);
        nwr  = m_wr + int'(s.awv && s.awr && wr_open(s.drn)) - int'(s.bv && s.br);
        uset = 0;
        if (nrd < 0) begin nrd = 0; uset = 1; end
        if (nwr < 0) begin nwr = 0; uset = 1; end
        tset = 0;
        if (m_rd == 0 || (s.rv && s.rr)) m_rd_mark = m_edge;
        else if (m_edge - m_rd_mark == TMO) begin tset = 1; m_rd_mark = m_edge; end
        if (m_wr == 0 || (s.bv && s.br)) m_wr_mark = m_edge;
        else if (m_edge - m_wr_mark == TMO) begin tset = 1; m_wr_mark = m_edge; end
        m_tmo = tset || (m_tmo && !s.clr);
        m_unf = uset || (m_unf && !s.clr);
        case (m_mode)
            0: if (s.drn) m_mode = 1;
            1: if (!s.drn) m_mode = 0; else if (nrd == 0 && nwr == 0) m_mode = 2;
            default: if (!s.drn) m_mode = 0;
        endcase
        m_rd = nrd;
        m_wr = nwr;
    endtask

    // Called just after a rising edge; returns just after the next one
    task automatic step(input stim_t s);
        exp_t e;
        rst            = s.rst;
        bus.ar_valid_i = s.arv; bus.ar_ready_i = s.arr;
        bus.aw_valid_i = s.awv; bus.aw_ready_i = s.awr;
        bus.r_valid_i  = s.rv;  bus.r_ready_i  = s.rr; bus.r_last_i = s.rl;
        bus.b_valid_i  = s.bv;  bus.b_ready_i  = s.br;
        drain_req      = s.drn; clr = s.clr;
        e.arv     = s.arv && rd_open(s.drn);
        e.arr     = s.arr && rd_open(s.drn);
        e.awv     = s.awv && wr_open(s.drn);
        e.awr     = s.awr && wr_open(s.drn);
        e.rd      = 4'(m_rd);
        e.wr      = 4'(m_wr);
        e.tmo     = m_tmo;
        e.unf     = m_unf;
        e.drained = (m_mode == 2);
        sb_q.push_back(e);
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic idle(input int n);
        stim_t s = '0;
        repeat (n) step(s);
    endtask

    task automatic do_reset();
        stim_t s = '0;
        s.rst = 1'b1;
        step(s);
    endtask

    // Monitor: scores every cycle the driver has posted an expectation for
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("ar_valid_o", int'(bus.ar_valid_o), int'(e.arv));
                chk("ar_ready_o", int'(bus.ar_ready_o), int'(e.arr));
                chk("aw_valid_o", int'(bus.aw_valid_o), int'(e.awv));
                chk("aw_ready_o", int'(bus.aw_ready_o), int'(e.awr));
                chk("rd_cnt_o",   int'(rd_cnt),    int'(e.rd));
                chk("wr_cnt_o",   int'(wr_cnt),    int'(e.wr));
                chk("timeout_o",  int'(timeout),   int'(e.tmo));
                chk("underflow_o",int'(underflow), int'(e.unf));
                chk("drained_o",  int'(drained),   int'(e.drained));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, got running expected done");
        $fatal(1, "timeout");
    end

    initial begin
        stim_t s;
        bit    drn_lvl;
        m_edge = 0;
        model_reset();
        rst = 1'b1; drain_req = 1'b0; clr = 1'b0;
        bus.ar_valid_i = 1'b0; bus.ar_ready_i = 1'b0;
        bus.aw_valid_i = 1'b0; bus.aw_ready_i = 1'b0;
        bus.r_valid_i = 1'b0; bus.r_ready_i = 1'b0; bus.r_last_i = 1'b0;
        bus.b_valid_i = 1'b0; bus.b_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        chk("reset_rd_cnt", int'(rd_cnt), 0);
        chk("reset_drained", int'(drained), 0);

        // Read cap: 10 requests, 8 admitted
        s = '0; s.arv = 1; s.arr = 1;
        repeat (10) step(s);
        chk("cap_rd_cnt", int'(rd_cnt), 8);
        chk("cap_ar_ready", int'(bus.ar_ready_o), 0);

        // Last beat frees a slot; the pending request enters one cycle later
        s = '0; s.arv = 1; s.arr = 1; s.rv = 1; s.rr = 1; s.rl = 1;
        step(s);
        chk("unblock_rd_cnt", int'(rd_cnt), 7);
        s = '0; s.arv = 1; s.arr = 1;
        step(s);
        chk("refill_rd_cnt", int'(rd_cnt), 8);

        // Write stall watchdog
        do_reset();
        s = '0; s.awv = 1; s.awr = 1;
        repeat (3) step(s);
        idle(1021);
        chk("wd_before", int'(timeout), 0);
        idle(1);
        chk("wd_fire", int'(timeout), 1);
        s = '0; s.clr = 1;
        step(s);
        chk("wd_clr", int'(timeout), 0);
        idle(1022);
        chk("wd_rearm_before", int'(timeout), 0);
        idle(1);
        chk("wd_refire", int'(timeout), 1);

        // Underflow and clear-vs-set priority
        do_reset();
        s = '0; s.bv = 1; s.br = 1;
        step(s);
        chk("unf_wr_cnt", int'(wr_cnt), 0);
        chk("unf_set", int'(underflow), 1);
        s = '0; s.clr = 1;
        step(s);
        chk("unf_clr", int'(underflow), 0);
        s = '0; s.bv = 1; s.br = 1;
        step(s);
        s.clr = 1;
        step(s);
        chk("unf_set_wins", int'(underflow), 1);

        // Drain with 2 reads and 1 write outstanding
        do_reset();
        s = '0; s.arv = 1; s.arr = 1; s.awv = 1; s.awr = 1;
        step(s);
        s.awv = 0;
        step(s);
        s = '0; s.arv = 1; s.arr = 1; s.awv = 1; s.awr = 1; s.drn = 1;
        s.rv = 1; s.rr = 1; s.rl = 1;
        step(s);
        s.rv = 0; s.bv = 1; s.br = 1;
        step(s);
        chk("drain_not_done", int'(drained), 0);
        s.bv = 0; s.rv = 1;
        step(s);
        chk("drain_done", int'(drained), 1);
        s = '0; s.drn = 1;
        step(s);
        s = '0; s.arv = 1; s.arr = 1;
        step(s);
        chk("drain_exit", int'(drained), 0);
        step(s);
        chk("drain_resume_rd", int'(rd_cnt), 1);

        // Reset mid-operation with 5/3 outstanding and timeout set
        do_reset();
        for (int i = 0; i < 5; i++) begin
            s = '0; s.arv = 1; s.arr = 1;
            s.awv = (i < 3); s.awr = 1;
            step(s);
        end
        idle(1030);
        chk("pre_rst_tmo", int'(timeout), 1);
        chk("pre_rst_rd", int'(rd_cnt), 5);
        do_reset();
        chk("mid_rst_rd", int'(rd_cnt), 0);
        chk("mid_rst_wr", int'(wr_cnt), 0);
        chk("mid_rst_tmo", int'(timeout), 0);

        // Random traffic
        drn_lvl = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 39) == 0) drn_lvl = !drn_lvl;
            s.rst = ($urandom_range(0, 599) == 0);
            s.arv = $urandom_range(0, 1); s.arr = ($urandom_range(0, 3) != 0);
            s.awv = $urandom_range(0, 1); s.awr = ($urandom_range(0, 3) != 0);
            s.rv  = ($urandom_range(0, 2) == 0); s.rr = $urandom_range(0, 1);
            s.rl  = $urandom_range(0, 1);
            s.bv  = ($urandom_range(0, 3) == 0); s.br = $urandom_range(0, 1);
            s.drn = drn_lvl;
            s.clr = ($urandom_range(0, 19) == 0);
            step(s);
        end

        idle(2);
        @(negedge clk);
        #1;
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
